// File: rtl/mem_req_arbiter.sv
// Two-master to one SRAM-port arbiter: combinational grant (data over inst), grant held to addr_ok, in-order ID queue routes data_ok.
// Zero added latency; grants stall while the queue is full. Define ARB_INST_DISCARD_EN to drop fetch responses across a flush.
module mem_req_arbiter #(
  parameter int OUTST_DEPTH = 2,
  parameter int PTR_W       = $clog2(OUTST_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  input  logic             flush,
  output logic [PTR_W:0]   outst_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                 state, state_nxt;
  logic                   sel_i, sel_d;
  logic                   full, push, pop;
  logic                   head_id, head_disc;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W:0]         cnt;
  logic [OUTST_DEPTH-1:0] id_q;

  assign full = (cnt == (PTR_W+1)'(OUTST_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fullness only gates a fresh grant; a held grant already had room reserved.
  always_comb begin
    sel_i     = 1'b0;
    sel_d     = 1'b0;
    state_nxt = IDLE;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (!full) begin
            if (data_req)      sel_d = 1'b1;
            else if (inst_req) sel_i = 1'b1;
          end
        end
        HOLD_I:  sel_i = inst_req;
        HOLD_D:  sel_d = data_req;
        default: ;
      endcase
      if (sel_i && !mem_addr_ok)      state_nxt = HOLD_I;
      else if (sel_d && !mem_addr_ok) state_nxt = HOLD_D;
    end
  end

  assign mem_req      = sel_i | sel_d;
  assign mem_wr       = sel_d & data_wr;
  assign mem_size     = sel_d ? data_size  : (sel_i ? inst_size : 2'b00);
  assign mem_wstrb    = sel_d ? data_wstrb : 4'b0000;
  assign mem_addr     = sel_d ? data_addr  : (sel_i ? inst_addr : 32'h0);
  assign mem_wdata    = sel_d ? data_wdata : 32'h0;
  assign inst_addr_ok = sel_i & mem_addr_ok;
  assign data_addr_ok = sel_d & mem_addr_ok;

  assign push    = mem_req & mem_addr_ok;
  assign pop     = !reset & mem_data_ok & (cnt != '0);
  assign head_id = id_q[rd_ptr];

  assign inst_data_ok = pop & !head_id & !head_disc;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;
  assign outst_cnt    = cnt;

  // ID 0 = inst, 1 = data; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      id_q   <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr] <= sel_d;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

`ifdef ARB_INST_DISCARD_EN
  logic [OUTST_DEPTH-1:0] disc_q;
  logic                   pend_disc;

  // A flush seen while an inst grant is still waiting for addr_ok is remembered
  // and applied to that entry when it is finally pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      disc_q    <= '0;
      pend_disc <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < OUTST_DEPTH; i++) begin
          if (!id_q[i]) disc_q[i] <= 1'b1;
        end
      end
      if (push) disc_q[wr_ptr] <= sel_i & (flush | pend_disc);
      pend_disc <= (state_nxt == HOLD_I) & (pend_disc | flush);
    end
  end

  assign head_disc = disc_q[rd_ptr];
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign head_disc    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed vector bench for mem_req_arbiter: a per-cycle stimulus/expectation table plus hand sequences for hold, full queue, reset and flush.
module tb_mem_req_arbiter;

`ifdef ARB_INST_DISCARD_EN
  localparam bit DISC = 1'b1;
`else
  localparam bit DISC = 1'b0;
`endif

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [1:0]  dsize;
    logic [3:0]  dwstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        maok;
    logic        mdok;
    logic [31:0] mrdata;
    logic        flush;
    logic        rst;
  } in_t;

  typedef struct packed {
    logic        mreq;
    logic        mwr;
    logic [1:0]  msize;
    logic [3:0]  mwstrb;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        iaok;
    logic        daok;
    logic        idok;
    logic [31:0] irdata;
    logic        ddok;
    logic [31:0] drdata;
    logic [1:0]  cnt;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } row_t;

  logic        clk, reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        flush;
  logic [1:0]  outst_cnt;

  int checks = 0;
  int errors = 0;

  mem_req_arbiter #(.OUTST_DEPTH(2), .PTR_W(1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .flush(flush), .outst_cnt(outst_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: drive after the rising edge, compare on the falling edge.
  task automatic step(input string nm, input in_t vi, input exp_t ve);
    exp_t act;
    inst_req    = vi.ireq;
    inst_addr   = vi.iaddr;
    data_req    = vi.dreq;
    data_wr     = vi.dwr;
    data_size   = vi.dsize;
    data_wstrb  = vi.dwstrb;
    data_addr   = vi.daddr;
    data_wdata  = vi.dwdata;
    mem_addr_ok = vi.maok;
    mem_data_ok = vi.mdok;
    mem_rdata   = vi.mrdata;
    flush       = vi.flush;
    reset       = vi.rst;
    @(negedge clk);
    act = {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
           inst_addr_ok, data_addr_ok, inst_data_ok, inst_rdata,
           data_data_ok, data_rdata, outst_cnt};
    checks++;
    if (act !== ve) begin
      errors++;
      $display("FAIL %s: got req=%b wr=%b sz=%0d strb=%b addr=%h wd=%h iaok=%b daok=%b idok=%b ird=%h ddok=%b drd=%h cnt=%0d; expected req=%b wr=%b sz=%0d strb=%b addr=%h wd=%h iaok=%b daok=%b idok=%b ird=%h ddok=%b drd=%h cnt=%0d",
               nm, act.mreq, act.mwr, act.msize, act.mwstrb, act.maddr, act.mwdata, act.iaok, act.daok, act.idok, act.irdata, act.ddok, act.drdata, act.cnt,
               ve.mreq, ve.mwr, ve.msize, ve.mwstrb, ve.maddr, ve.mwdata, ve.iaok, ve.daok, ve.idok, ve.irdata, ve.ddok, ve.drdata, ve.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  // in_t  : ireq iaddr dreq dwr dsize dwstrb daddr dwdata maok mdok mrdata flush rst
  // exp_t : mreq mwr msize mwstrb maddr mwdata iaok daok idok irdata ddok drdata cnt
  localparam logic [31:0] Z = 32'h0;
  localparam exp_t E0 = '0;

  function automatic in_t nop();
    return '0;
  endfunction

  function automatic exp_t idle(input logic [1:0] c);
    exp_t e;
    e = '0;
    e.cnt = c;
    return e;
  endfunction

  row_t tbl [16];

  initial begin
    inst_size = 2'd2;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = Z; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_wstrb = 4'h0; data_addr = Z; data_wdata = Z; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    mem_rdata = Z; flush = 1'b0;
    @(posedge clk);
    #1;

    tbl[0]  = '{'{1'b1, 32'h1c000000, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1}, E0};
    tbl[1]  = '{'{1'b1, 32'h1c000000, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000000, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0}};
    tbl[2]  = '{nop(), idle(2'd1)};
    tbl[3]  = '{'{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h02800c04, 1'b0, 1'b0},
                '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'h02800c04, 1'b0, Z, 2'd1}};
    tbl[4]  = '{nop(), idle(2'd0)};
    tbl[5]  = '{'{1'b1, 32'h1c000004, 1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008000, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008000, Z, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 2'd0}};
    tbl[6]  = '{'{1'b1, 32'h1c000004, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000004, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd1}};
    tbl[7]  = '{'{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0},
                '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b0, Z, 1'b1, 32'h11, 2'd2}};
    tbl[8]  = '{'{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0},
                '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0, Z, 2'd1}};
    tbl[9]  = '{'{1'b0, Z, 1'b1, 1'b1, 2'd1, 4'b0011, 32'h1c008010, 32'h12345678, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                '{1'b1, 1'b1, 2'd1, 4'b0011, 32'h1c008010, 32'h12345678, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 2'd0}};
    tbl[10] = '{'{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, Z, 1'b0, 1'b0},
                '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b0, Z, 1'b1, Z, 2'd1}};
    tbl[11] = '{'{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'hdead, 1'b0, 1'b0}, idle(2'd0)};
    tbl[12] = '{'{1'b1, 32'h1c000008, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000008, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0}};
    tbl[13] = '{'{1'b1, 32'h1c00000c, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0},
                '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c00000c, Z, 1'b1, 1'b0, 1'b1, 32'h33, 1'b0, Z, 2'd1}};
    tbl[14] = '{'{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0},
                '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, Z, 2'd1}};
    tbl[15] = '{nop(), idle(2'd0)};

    for (int k = 0; k < 16; k++) step($sformatf("tbl%0d", k), tbl[k].i, tbl[k].e);

    // Grant held on inst for 3 cycles of addr_ok=0 while the higher-priority data request waits.
    for (int k = 0; k < 3; k++)
      step($sformatf("hold%0d", k),
           '{1'b1, 32'h1c000010, (k > 0), 1'b0, 2'd2, 4'h0, 32'h1c008020, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0},
           '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000010, Z, 1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("hold3", '{1'b1, 32'h1c000010, 1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008020, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000010, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("hold4", '{1'b0, Z, 1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008020, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008020, Z, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 2'd1});
    step("hold5", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0, Z, 2'd2});
    step("hold6", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h2, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b0, Z, 1'b1, 32'h2, 2'd1});
    step("hold7", nop(), idle(2'd0));

    // Queue full: third request blocked, and a same-cycle pop does not release it.
    step("full0", '{1'b1, 32'h1c000020, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000020, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("full1", '{1'b0, Z, 1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008030, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008030, Z, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 2'd1});
    step("full2", '{1'b1, 32'h1c000024, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0}, idle(2'd2));
    step("full3", '{1'b1, 32'h1c000024, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b1, 32'hA, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0, Z, 2'd2});
    step("full4", '{1'b1, 32'h1c000024, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b1, 32'hB, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000024, Z, 1'b1, 1'b0, 1'b0, Z, 1'b1, 32'hB, 2'd1});
    step("full5", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'hC, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'hC, 1'b0, Z, 2'd1});
    step("full6", nop(), idle(2'd0));

    // Reset with one transaction outstanding drops it; a later data_ok is ignored.
    step("rst0", '{1'b1, 32'h1c000040, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                 '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000040, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("rst1", '{1'b1, 32'h1c000044, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b1}, idle(2'd1));
    step("rst2", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h99, 1'b0, 1'b0}, idle(2'd0));

    // Flush: fetch responses are discarded only when the discard feature is built in.
    step("disc0", '{1'b1, 32'h1c000050, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000050, Z, 1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("disc1", '{1'b1, 32'h1c000050, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000050, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("disc2", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, !DISC, DISC ? Z : 32'h55, 1'b0, Z, 2'd1});
    step("disc3", nop(), idle(2'd0));
    step("disc4", '{1'b1, 32'h1c000054, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000054, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("disc5", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h66, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b1, 32'h66, 1'b0, Z, 2'd1});
    step("disc6", '{1'b1, 32'h1c000058, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b1, 1'b0, Z, 1'b0, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c000058, Z, 1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 2'd0});
    step("disc7", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, Z, 1'b1, 1'b0}, idle(2'd1));
    step("disc8", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, !DISC, DISC ? Z : 32'h77, 1'b0, Z, 2'd1});
    step("disc9", '{1'b0, Z, 1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008040, Z, 1'b1, 1'b0, Z, 1'b1, 1'b0},
                  '{1'b1, 1'b0, 2'd2, 4'h0, 32'h1c008040, Z, 1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 2'd0});
    step("disc10", '{1'b0, Z, 1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0},
                   '{1'b0, 1'b0, 2'd0, 4'h0, Z, Z, 1'b0, 1'b0, 1'b0, Z, 1'b1, 32'h88, 2'd1});
    step("disc11", nop(), idle(2'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates the instruction-fetch and data (EX/MEM) SRAM-like request interfaces onto one shared downstream SRAM-like memory port (req/addr_ok/data_ok protocol).
- Holds a grant stable until addr_ok, and tracks outstanding transactions in an in-order ID queue.
- Routes each data_ok/rdata back to the originating requester.
- Sits between the pipeline stages and the memory bridge.

Parameters:
- OUTST_DEPTH, 2, maximum outstanding (address-accepted, data not yet returned) transactions; power of 2, ≥2.
- PTR_W, 1, log2(OUTST_DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request valid (read only)
- inst_size  in  2  bytes = 1<<size
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data returned
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request valid
- data_wr  in  1  1 = store
- data_size  in  2  access size
- data_wstrb  in  4  byte enables
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  load data returned / store done
- data_rdata  out  32  load data
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  granted requester's fields
- mem_addr_ok  in  1  downstream address accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data
- flush  in  1  pipeline flush (ertn/exception/tlb refetch)
- outst_cnt  out  PTR_W+1  current queue occupancy

Behaviour:
- Reset: state IDLE; queue empty; outst_cnt=0; all *_addr_ok, *_data_ok, mem_req = 0. Reset mid-transaction drops all queue entries.
- States:
  - IDLE: no grant held.
  - HOLD_I: inst granted, waiting for mem_addr_ok.
  - HOLD_D: data granted, waiting for mem_addr_ok.
- IDLE grant is combinational, same cycle as the request:
  - If queue full: no grant, mem_req=0. A pop in the same cycle does not unblock the grant.
  - Otherwise data_req has priority over inst_req (data is the older instruction).
  - mem_req=1, and mem_* is driven from the granted requester (inst: mem_wr=0, mem_wstrb=0, mem_wdata=0).
- Address handshake when mem_addr_ok=1 with mem_req=1:
  - Granted requester's *_addr_ok = 1 for that cycle.
  - Push requester ID (0 = inst, 1 = data) at the queue tail.
  - Next state IDLE.
- If mem_addr_ok=0: next state HOLD_I or HOLD_D.
  - In HOLD_x, mem_req and mem_* track the held requester only; the other requester is not served even if higher priority.
  - Return to IDLE on mem_addr_ok.
- Response routing: mem_data_ok=1 with queue non-empty → assert head ID's *_data_ok for one cycle, *_rdata = mem_rdata, pop head.
  - Non-selected rdata output = 0.
  - mem_data_ok with queue empty is ignored (protocol violation, no output pulse).
- Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo OUTST_DEPTH.
- Throughput: one accepted request per cycle when mem_addr_ok is held high and queue not full. Minimum latency addr→data is set by downstream; the arbiter adds zero cycles.
- No *_addr_ok is ever asserted without the matching mem_addr_ok.

Optional Feature:
- Macro ARB_INST_DISCARD_EN.
- Defined:
  - Each queue entry carries a discard bit. flush=1 sets discard on all valid inst entries, including one pushed in the same cycle.
  - A popped entry with discard=1 consumes mem_data_ok but holds inst_data_ok=0.
  - flush in HOLD_I keeps the grant until addr_ok (protocol requires it), then marks that entry discard.
  - Data entries are unaffected.
- Undefined: flush ignored; all responses forwarded.

Test Plan:
- inst_req=1, addr 0x1c000000, mem_addr_ok=1 same cycle; mem_data_ok 2 cycles later, rdata 0x02800c04 → inst_addr_ok pulse cycle 0, inst_data_ok with inst_rdata=0x02800c04 cycle 2, outst_cnt 0→1→0.
- inst_req and data_req (load 0x1c008000) both high in IDLE, mem_addr_ok=1 → data granted first (mem_addr=0x1c008000), inst granted next cycle.
- inst_req at cycle 0, mem_addr_ok low for 3 cycles, data_req rises cycle 1 → state HOLD_I, mem_addr stays inst address until addr_ok at cycle 3; data granted cycle 4.
- Three back-to-back requests (I, D, I) with mem_addr_ok=1 and no data_ok → third blocked (mem_req=0, outst_cnt=2). Two data_ok with rdata 0xA, 0xB → inst_data_ok/0xA then data_data_ok/0xB, then third is granted.
- Store: data_wr=1, wstrb=4'b0011, wdata 0x12345678 → mem_wr=1, mem_wstrb=0011 passed; data_data_ok on response.
- ARB_INST_DISCARD_EN: inst outstanding, flush=1, then mem_data_ok → inst_data_ok stays 0, outst_cnt→0; the next inst fetch returns normally.
